// File: rtl/tt_pin_initiator.sv
// Host-side initiator for a four-phase pin handshake with a user project.
// Queues command bytes, presents each on pin_data, raises pin_req, captures
// uo_in on the (synchronised) acknowledge and reports one response per command.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the head when one exists
// SETUP  | pin_data already driven, pin_req held low for one settling cycle
// REQ_HI | pin_req high, waiting for ack_s to rise (or timeout)
// REQ_LO | pin_req low, waiting for ack_s to fall (or timeout)
// DONE   | one-cycle response pulse, then back to IDLE
module tt_pin_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] pin_data,
  output logic       pin_req,
  input  logic       pin_ack,
  input  logic [7:0] uo_in,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, DONE} state_t;

  // Timeout fires on the edge that completes the TIMEOUT-th cycle in a wait state.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        ready_en_q;
  logic        ack_meta_q, ack_s_q;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [7:0]  pin_data_q, pin_data_d;
  logic        push, pop;

  assign cmd_ready = ready_en_q && (count_q != 3'd4);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != 3'd0);

  assign rsp_valid = (state_q == DONE);
  assign rsp_err   = (state_q == DONE) && err_q;
  assign pin_req   = (state_q == REQ_HI);
  assign busy      = (state_q != IDLE) || (count_q != 3'd0);
  assign rsp_data  = rsp_data_q;
  assign pin_data  = pin_data_q;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_data;
  end

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= pin_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Handshake state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= 8'd0;
      err_q      <= 1'b0;
      rsp_data_q <= 8'd0;
      pin_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      pin_data_q <= pin_data_d;
    end
  end

  // Next-state logic: handshake sequencing, wait counting and timeouts.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    pin_data_d = pin_data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          pin_data_d = fifo_mem[rd_ptr_q];
          state_d    = SETUP;
        end
      end
      SETUP: begin
        wait_d  = 8'd0;
        state_d = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s_q) begin
          rsp_data_d = uo_in;
          wait_d     = 8'd0;
          state_d    = REQ_LO;
        end else if (wait_q == WAIT_LAST) begin
          err_d      = 1'b1;
          rsp_data_d = 8'd0;
          wait_d     = 8'd0;
          state_d    = REQ_LO;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      REQ_LO: begin
        if (!ack_s_q) begin
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tt_pin_initiator.sv
// Directed bench for tt_pin_initiator: a transaction-level scoreboard predicts
// each response from the command byte and how the responder behaved for it.
module tb_tt_pin_initiator;

  localparam int TMO = 10;

  // expected response kinds
  localparam int M_OK    = 0;
  localparam int M_NEVER = 1;
  localparam int M_STUCK = 2;

  // responder behaviours
  localparam int R_ACK    = 0;
  localparam int R_NONE   = 1;
  localparam int R_STUCK  = 2;
  localparam int R_MANUAL = 3;

  typedef struct {
    logic [7:0] cmd;
    int         mode;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready, rsp_valid, rsp_err, pin_req, busy;
  logic [7:0] rsp_data, pin_data;
  logic       pin_ack;
  logic [7:0] uo_in = 8'hEE;
  logic       resp_ack = 1'b0;
  logic       glitch_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  int push_cyc = 0;
  int rmode = R_ACK;
  int rdelay = 0;
  int rcnt = 0;
  logic [7:0] last_rsp_data = 8'd0;
  logic       last_rsp_err = 1'b0;
  logic       acc;
  ent_t       exp_q[$];

  assign pin_ack = resp_ack | glitch_ack;

  tt_pin_initiator #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pin_data(pin_data), .pin_req(pin_req), .pin_ack(pin_ack),
    .uo_in(uo_in), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] resp_fn(input logic [7:0] b);
    return b ^ 8'h99;
  endfunction

  // Responder: drives uo_in from pin_data while requested, garbage otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (pin_req) uo_in = resp_fn(pin_data);
      else         uo_in = 8'hEE;
      case (rmode)
        R_ACK: begin
          if (pin_req) begin
            if (!resp_ack) begin
              if (rcnt == rdelay) resp_ack = 1'b1;
              else                rcnt++;
            end
          end else begin
            resp_ack = 1'b0;
            rcnt     = 0;
          end
        end
        R_STUCK: if (pin_req) resp_ack = 1'b1;
        default: begin
          resp_ack = 1'b0;
          rcnt     = 0;
        end
      endcase
    end
  end

  // Compare process: scoreboard checks on every sample outside reset.
  initial begin
    logic       prev_req, prev_valid;
    logic [7:0] prev_pd;
    int         hi_len, lo_cnt;
    ent_t       e;
    logic [7:0] exp_d;
    logic       exp_e;
    prev_req = 1'b0; prev_valid = 1'b0; prev_pd = 8'd0; hi_len = 0; lo_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0; prev_valid = 1'b0; prev_pd = 8'd0; hi_len = 0; lo_cnt = 0;
      end else begin
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
        if (pin_req) begin
          if (!prev_req) begin
            hi_len = 1;
            chk("pin_data_setup", 32'(pin_data), 32'(prev_pd));
          end else begin
            hi_len++;
          end
          if (exp_q.size() == 0) chk("req_without_cmd", 32'(pin_req), 0);
          else                   chk("pin_data_hold", 32'(pin_data), 32'(exp_q[0].cmd));
        end else begin
          if (prev_req) begin
            lo_cnt = 0;
            if (exp_q.size() != 0 && exp_q[0].mode == M_NEVER)
              chk("req_hi_len", hi_len, TMO);
          end else begin
            lo_cnt++;
          end
        end
        if (rsp_valid) begin
          chk("rsp_pulse", 32'(prev_valid), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 0);
          end else begin
            e = exp_q.pop_front();
            exp_d = (e.mode == M_NEVER) ? 8'h00 : resp_fn(e.cmd);
            exp_e = (e.mode != M_OK);
            chk("rsp_data", 32'(rsp_data), 32'(exp_d));
            chk("rsp_err", 32'(rsp_err), 32'(exp_e));
            if (e.mode == M_STUCK) chk("req_lo_len", lo_cnt, TMO);
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_err;
            last_rsp_cyc  = cyc;
            rsp_cnt++;
          end
        end
        prev_req   = pin_req;
        prev_valid = rsp_valid;
        prev_pd    = pin_data;
      end
    end
  end

  task automatic push(input logic [7:0] b, input int mode, output logic accepted);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    accepted  = cmd_ready;
    @(posedge clk);
    #1;
    push_cyc  = cyc;
    if (accepted) exp_q.push_back('{b, mode});
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("rsp_arrived", 32'(rsp_cnt >= target), 1);
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!pin_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("req_rose", 32'(pin_req), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pin_req",   32'(pin_req), 0);
    chk("rst_pin_data",  32'(pin_data), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data",  32'(rsp_data), 0);
    chk("rst_rsp_err",   32'(rsp_err), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_busy",      32'(busy), 0);
    rst = 1'b0;
    #1 chk("ready_before_edge", 32'(cmd_ready), 0);
    @(posedge clk);
    #1 chk("ready_after_edge", 32'(cmd_ready), 1);

    // single command, ack two cycles after request
    rmode = R_ACK; rdelay = 2;
    push(8'hA5, M_OK, acc);
    wait_rsp(1, 40);
    chk("lat_a5", last_rsp_cyc - push_cyc, 10);
    chk("data_a5", 32'(last_rsp_data), 'h3C);
    chk("err_a5", 32'(last_rsp_err), 0);

    // immediate responder: minimum transaction time
    rdelay = 0;
    push(8'h11, M_OK, acc);
    wait_rsp(2, 40);
    chk("lat_min", last_rsp_cyc - push_cyc, 8);
    chk("data_11", 32'(last_rsp_data), 'h88);

    // stalled responder: fill the FIFO, refuse the sixth, then drain in order
    rmode = R_MANUAL;
    for (int i = 1; i <= 5; i++) push(8'(i), M_OK, acc);
    chk("full_ready", 32'(cmd_ready), 0);
    push(8'h66, M_OK, acc);
    chk("full_refused", 32'(acc), 0);
    rmode = R_ACK; rdelay = 0;
    wait_rsp(7, 120);
    chk("data_last_of_5", 32'(last_rsp_data), 'h9C);

    // responder never acks: timeout in REQ_HI
    rmode = R_NONE;
    push(8'h77, M_NEVER, acc);
    wait_rsp(8, 60);
    chk("lat_tmo_hi", last_rsp_cyc - push_cyc, 13);
    chk("data_tmo_hi", 32'(last_rsp_data), 0);
    chk("err_tmo_hi", 32'(last_rsp_err), 1);

    // ack stuck high: timeout in REQ_LO keeps the captured byte
    rmode = R_STUCK;
    push(8'h42, M_STUCK, acc);
    wait_rsp(9, 60);
    chk("lat_tmo_lo", last_rsp_cyc - push_cyc, 15);
    chk("data_tmo_lo", 32'(last_rsp_data), 'hDB);
    chk("err_tmo_lo", 32'(last_rsp_err), 1);
    rmode = R_ACK;
    repeat (4) @(negedge clk);

    // sub-cycle ack glitches: one between edges, one straddling an edge
    rmode = R_MANUAL;
    push(8'h30, M_OK, acc);
    wait_req(20);
    #1 glitch_ack = 1'b1;
    #2 glitch_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_ignored", 32'(pin_req), 1);
    #4 glitch_ack = 1'b1;
    @(posedge clk);
    #1 glitch_ack = 1'b0;
    wait_rsp(10, 40);
    chk("data_glitch", 32'(last_rsp_data), 'hA9);

    // reset while in REQ_HI with two commands queued
    rmode = R_MANUAL;
    push(8'hB1, M_OK, acc);
    push(8'hB2, M_OK, acc);
    push(8'hB3, M_OK, acc);
    wait_req(20);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_pin_req", 32'(pin_req), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(cmd_ready), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_before_edge2", 32'(cmd_ready), 0);
    @(posedge clk);
    #1 chk("ready_after_edge2", 32'(cmd_ready), 1);
    rmode = R_ACK; rdelay = 0;
    repeat (12) @(negedge clk);
    chk("no_rsp_after_abort", rsp_cnt, 10);
    push(8'h5E, M_OK, acc);
    wait_rsp(11, 40);
    chk("data_after_abort", 32'(last_rsp_data), 'hC7);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
